// File: rtl/prog_loader_if.sv
// Byte-link and instruction-RAM write bundle for the program loader.
//   in_data/in_valid/in_ready : host byte stream. A byte moves when in_valid & in_ready.
//   imem_we/imem_addr/imem_wdata : instruction RAM write port (one-cycle write strobe).
// modport slave  : the loader side. It consumes bytes and drives the RAM port.
// modport master : the host/RAM side. It drives bytes and observes the RAM port.
interface prog_loader_if #(
  parameter int unsigned I_ADDR_W = 7,
  parameter int unsigned WIDTH    = 16
);
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic                imem_we;
  logic [I_ADDR_W-1:0] imem_addr;
  logic [WIDTH-1:0]    imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Byte-stream program loader. It writes 16-bit instructions into the instruction RAM
// and holds the CPU in reset while a program is being loaded.
// Frame: 0xA5, LEN, LEN x {hi, lo} [, CHK = XOR of LEN and all data bytes].
// Optional feature: define PROG_LOADER_CHECKSUM_EN to expect and verify the CHK byte.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   bus (slave)     : byte link in, instruction RAM write port out
//   o_cpu_rst       : CPU reset. High while loading or after an error.
//   o_busy          : high from the start byte until the load finishes or fails
//   o_done          : one-cycle pulse when a load succeeds
//   o_err           : sticky error flag. Cleared by the next start byte.
//   o_words_loaded  : number of words written by the current or last load
module prog_loader #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned I_ADDR_W  = 7,
  parameter bit          BOOT_HOLD = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.slave      bus,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [I_ADDR_W:0] o_words_loaded
);

  localparam int unsigned MAX_WORDS = 1 << I_ADDR_W;
  localparam logic [7:0]  START     = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_HI, ST_LO, ST_CHK, ST_ERR
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_in_ready, w_in_ready_nxt;
  logic                r_we, w_we_nxt;
  logic [I_ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [WIDTH-1:0]    r_wdata, w_wdata_nxt;
  logic                r_cpu_rst, w_cpu_rst_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;
  logic [I_ADDR_W:0]   r_words, w_words_nxt;
  logic [7:0]          r_len, w_len_nxt;
  logic [I_ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [7:0]          r_hi, w_hi_nxt;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          r_chk, w_chk_nxt;
`endif
  logic                w_acc;
  logic                w_last;

  assign w_acc  = bus.in_valid & r_in_ready;
  // The word being accepted in LO is the last one of the frame.
  assign w_last = (32'(r_idx) + 32'd1) == 32'(r_len);

  // Next-state and next-register logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_in_ready_nxt = 1'b1;
    w_we_nxt       = 1'b0;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_cpu_rst_nxt  = r_cpu_rst;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_err_nxt      = r_err;
    w_words_nxt    = r_words;
    w_len_nxt      = r_len;
    w_idx_nxt      = r_idx;
    w_hi_nxt       = r_hi;
`ifdef PROG_LOADER_CHECKSUM_EN
    w_chk_nxt      = r_chk;
`endif
    if (w_acc) begin
      case (r_state)
        ST_IDLE, ST_ERR: begin
          if (bus.in_data == START) begin
            w_state_nxt   = ST_LEN;
            w_cpu_rst_nxt = 1'b1;
            w_busy_nxt    = 1'b1;
            w_err_nxt     = 1'b0;
            w_words_nxt   = '0;
            w_idx_nxt     = '0;
          end
        end
        ST_LEN: begin
          if (bus.in_data == 8'd0 || 32'(bus.in_data) > MAX_WORDS) begin
            w_state_nxt = ST_ERR;
            w_busy_nxt  = 1'b0;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_HI;
            w_len_nxt   = bus.in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
            w_chk_nxt   = bus.in_data;
`endif
          end
        end
        ST_HI: begin
          w_state_nxt = ST_LO;
          w_hi_nxt    = bus.in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          w_chk_nxt   = r_chk ^ bus.in_data;
`endif
        end
        ST_LO: begin
          // Write next cycle. Hold off the byte link for that one cycle.
          w_we_nxt       = 1'b1;
          w_in_ready_nxt = 1'b0;
          w_addr_nxt     = r_idx;
          w_wdata_nxt    = WIDTH'({r_hi, bus.in_data});
          w_words_nxt    = (I_ADDR_W+1)'(r_words + 1'b1);
          w_idx_nxt      = I_ADDR_W'(r_idx + 1'b1);
          w_state_nxt    = ST_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
          w_chk_nxt      = r_chk ^ bus.in_data;
          if (w_last) w_state_nxt = ST_CHK;
`else
          if (w_last) begin
            w_state_nxt   = ST_IDLE;
            w_done_nxt    = 1'b1;
            w_busy_nxt    = 1'b0;
            w_cpu_rst_nxt = 1'b0;
          end
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (bus.in_data == r_chk) begin
            w_state_nxt   = ST_IDLE;
            w_done_nxt    = 1'b1;
            w_busy_nxt    = 1'b0;
            w_cpu_rst_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_ERR;
            w_busy_nxt  = 1'b0;
            w_err_nxt   = 1'b1;
          end
        end
`endif
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_rst  <= BOOT_HOLD;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_words    <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_hi       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_chk      <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_cpu_rst  <= w_cpu_rst_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_words    <= w_words_nxt;
      r_len      <= w_len_nxt;
      r_idx      <= w_idx_nxt;
      r_hi       <= w_hi_nxt;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_chk      <= w_chk_nxt;
`endif
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign o_cpu_rst      = r_cpu_rst;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_words_loaded = r_words;

endmodule
